hit_judge: RTL and testbench
============================

HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 17'd99999, is the lockout length in clk cycles after an accepted button edge.
REQ-002 Parameter SCORE_W, default 16, is the score counter width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 red_button  input  1  raw player button for red notes, asynchronous to clk.
REQ-006 blue_button  input  1  raw player button for blue notes, asynchronous to clk.
REQ-007 note_R_judge  input  1  a red note occupies the judge slot.
REQ-008 note_B_judge  input  1  a blue note occupies the judge slot.
REQ-009 offset  input  3  pixel phase of the scrolling notes, 0..6.
REQ-010 combo  input  8  current combo count from the note-scroll stage.
REQ-011 finish  input  1  song-end indication from the note-scroll stage.
REQ-012 delete  output  1  one-cycle pulse that removes the note in the judge slot.
REQ-013 hit_perfect  output  1  one-cycle pulse on a perfect hit.
REQ-014 hit_good  output  1  one-cycle pulse on a good hit.
REQ-015 miss  output  1  one-cycle pulse on a wrong, empty or double press.
REQ-016 score  output  SCORE_W  accumulated score.
REQ-017 max_combo  output  8  highest combo value seen this song.
REQ-018 result_valid  output  1  high while the final results are frozen.

Function
REQ-019 Each button SHALL pass through a 2-flop synchronizer followed by rising-edge detection, giving 3 cycles of latency from the pin to the internal edge.
REQ-020 After an accepted edge, further edges on the same button SHALL be ignored for DEBOUNCE_CYC cycles (per-button lockout counter).
REQ-021 An internal arm flag SHALL be set on the cycle where (note_R_judge|note_B_judge) rises, or where offset wraps 6->0 while either judge bit is 1.
REQ-022 The arm flag SHALL clear on an accepted hit and whenever both judge bits are 0.
REQ-023 Accepted hit: arm=1 and exactly one button edge whose colour matches the asserted judge bit.
- On a hit, delete SHALL pulse 1 cycle later (registered output).
- On a hit, arm SHALL clear.
REQ-024 A hit SHALL be graded perfect when offset is in 2..4, adding 2 to score and pulsing hit_perfect; otherwise it SHALL be graded good, adding 1 to score and pulsing hit_good.
REQ-025 score SHALL saturate at all-ones and never wrap.
REQ-026 The following SHALL each produce a single miss pulse, with no delete and no score change:
- wrong colour;
- edge while arm=0;
- red and blue edges in the same cycle.
REQ-027 At most one of delete/miss SHALL be asserted per cycle; hit_perfect and hit_good SHALL be mutually exclusive and coincide with delete.
REQ-028 max_combo SHALL update to combo whenever combo > max_combo.
REQ-029 FSM states:
- PLAY: judging enabled.
- HOLD: judging disabled, score and max_combo frozen, result_valid=1.
REQ-030 Transitions:
- PLAY->HOLD when finish=1.
- HOLD->PLAY when finish=0; on this transition score, max_combo and arm SHALL clear.
REQ-031 Button edges in HOLD SHALL be discarded (no pulses), but lockout counters SHALL still run.

Reset
REQ-032 On rst: state=PLAY, and delete, hit_perfect, hit_good, miss, score, max_combo, result_valid, arm, synchronizers and lockout counters SHALL all be 0.
REQ-033 Asserting rst mid-press or mid-lockout SHALL abort both immediately; the first edge after release is judged normally.

Verification
REQ-034 Red note arrives (note_R_judge 0->1), offset=3, red press -> delete and hit_perfect pulse once; score 0->2.
REQ-035 Blue note present, offset=6, blue press -> hit_good; score +1; a second blue press within the lockout produces no pulse.
REQ-036 Red note present, blue press -> miss pulse only; score unchanged; a subsequent red press -> hit.
REQ-037 Red and blue edges in the same cycle with a red note present -> single miss, no delete.
REQ-038 combo sequence 3,7,0,5 -> max_combo=7; finish=1 -> result_valid=1 and a press does nothing; finish=0 -> score=0 and max_combo=0.
REQ-039 score preset near all-ones followed by a perfect hit -> score = all-ones.

Source files
------------

// File: rtl/hit_judge.sv
// hit_judge: synchronises and debounces the two player buttons, grades presses against
// the note in the judge slot, and keeps score and max combo until the song ends. Rev 1.0
`default_nettype none

module hit_judge #(
   parameter logic [16:0] DEBOUNCE_CYC = 17'd99999,
   parameter int          SCORE_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               red_button,
   input  logic               blue_button,
   input  logic               note_R_judge,
   input  logic               note_B_judge,
   input  logic [2:0]         offset,
   input  logic [7:0]         combo,
   input  logic               finish,
   output logic               delete,
   output logic               hit_perfect,
   output logic               hit_good,
   output logic               miss,
   output logic [SCORE_W-1:0] score,
   output logic [7:0]         max_combo,
   output logic               result_valid
);

   typedef enum logic [0:0] {
      ST_PLAY = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_delete;
   logic               r_hit_perfect;
   logic               r_hit_good;
   logic               r_miss;
   logic [SCORE_W-1:0] r_score;
   logic [7:0]         r_max_combo;
   logic               r_result_valid;
   logic               r_arm;
   logic               r_any_prev;
   logic [2:0]         r_off_prev;

   logic [1:0]         w_btn;
   logic [1:0]         w_acc;
   logic               w_note_any;
   logic               w_arm_set;
   logic               w_any_edge;
   logic               w_both;
   logic               w_match;
   logic               w_hit;
   logic               w_miss;
   logic               w_perfect_zone;
   logic [SCORE_W:0]   w_sum;
   logic [SCORE_W-1:0] w_score_next;

   assign w_btn = {blue_button, red_button};

   // Per button: 2-flop sync, registered rising edge, lockout after each accepted edge.
   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]  r_sync;
      logic        r_prev;
      logic        r_edge;
      logic [16:0] r_lock;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
            r_lock <= 17'd0;
         end else begin
            r_sync <= {r_sync[0], w_btn[gi]};
            r_prev <= r_sync[1];
            r_edge <= r_sync[1] & ~r_prev;
            if (r_edge && (r_lock == 17'd0)) begin
               r_lock <= DEBOUNCE_CYC;
            end else if (r_lock != 17'd0) begin
               r_lock <= r_lock - 17'd1;
            end
         end
      end

      assign w_acc[gi] = r_edge & (r_lock == 17'd0);
   end

   assign w_note_any     = note_R_judge | note_B_judge;
   assign w_arm_set      = (w_note_any & ~r_any_prev) |
                           (w_note_any & (r_off_prev == 3'd6) & (offset == 3'd0));
   assign w_any_edge     = w_acc[0] | w_acc[1];
   assign w_both         = w_acc[0] & w_acc[1];
   assign w_match        = (w_acc[0] & note_R_judge) | (w_acc[1] & note_B_judge);
   assign w_hit          = (r_state == ST_PLAY) & w_any_edge & ~w_both & r_arm & w_match;
   assign w_miss         = (r_state == ST_PLAY) & w_any_edge & ~w_hit;
   assign w_perfect_zone = (offset >= 3'd2) && (offset <= 3'd4);

   // One extra bit catches the carry so the score sticks at all-ones.
   assign w_sum        = {1'b0, r_score} + (w_perfect_zone ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
   assign w_score_next = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_PLAY;
         r_delete       <= 1'b0;
         r_hit_perfect  <= 1'b0;
         r_hit_good     <= 1'b0;
         r_miss         <= 1'b0;
         r_score        <= '0;
         r_max_combo    <= 8'd0;
         r_result_valid <= 1'b0;
         r_arm          <= 1'b0;
         r_any_prev     <= 1'b0;
         r_off_prev     <= 3'd0;
      end else begin
         r_any_prev <= w_note_any;
         r_off_prev <= offset;

         if (!w_note_any || w_hit) begin
            r_arm <= 1'b0;
         end else if (w_arm_set) begin
            r_arm <= 1'b1;
         end

         case (r_state)
            ST_PLAY: begin
               r_delete      <= w_hit;
               r_hit_perfect <= w_hit & w_perfect_zone;
               r_hit_good    <= w_hit & ~w_perfect_zone;
               r_miss        <= w_miss;
               if (w_hit) begin
                  r_score <= w_score_next;
               end
               if (combo > r_max_combo) begin
                  r_max_combo <= combo;
               end
               if (finish) begin
                  r_state        <= ST_HOLD;
                  r_result_valid <= 1'b1;
               end
            end
            ST_HOLD: begin
               r_delete      <= 1'b0;
               r_hit_perfect <= 1'b0;
               r_hit_good    <= 1'b0;
               r_miss        <= 1'b0;
               if (!finish) begin
                  r_state        <= ST_PLAY;
                  r_result_valid <= 1'b0;
                  r_score        <= '0;
                  r_max_combo    <= 8'd0;
                  r_arm          <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_PLAY;
            end
         endcase
      end
   end

   assign delete       = r_delete;
   assign hit_perfect  = r_hit_perfect;
   assign hit_good     = r_hit_good;
   assign miss         = r_miss;
   assign score        = r_score;
   assign max_combo    = r_max_combo;
   assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed test of hit_judge with a short lockout and a 3-bit score.
// Rev 1.0
`default_nettype none

module tb_hit_judge;

   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          red_button = 1'b0;
   logic          blue_button = 1'b0;
   logic          note_R_judge = 1'b0;
   logic          note_B_judge = 1'b0;
   logic [2:0]    offset = 3'd0;
   logic [7:0]    combo = 8'd0;
   logic          finish = 1'b0;
   logic          delete;
   logic          hit_perfect;
   logic          hit_good;
   logic          miss;
   logic [SW-1:0] score;
   logic [7:0]    max_combo;
   logic          result_valid;

   int checks = 0;
   int errors = 0;
   int n_del, n_perf, n_good, n_miss, n_bad;

   hit_judge #(
      .DEBOUNCE_CYC(17'd20),
      .SCORE_W     (SW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .red_button  (red_button),
      .blue_button (blue_button),
      .note_R_judge(note_R_judge),
      .note_B_judge(note_B_judge),
      .offset      (offset),
      .combo       (combo),
      .finish      (finish),
      .delete      (delete),
      .hit_perfect (hit_perfect),
      .hit_good    (hit_good),
      .miss        (miss),
      .score       (score),
      .max_combo   (max_combo),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive a press, then count every output pulse and exclusivity violation in the window.
   task automatic press(input logic r, input logic b);
      n_del = 0; n_perf = 0; n_good = 0; n_miss = 0; n_bad = 0;
      red_button  = r;
      blue_button = b;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (i == 1) begin
            red_button  = 1'b0;
            blue_button = 1'b0;
         end
         n_del  += int'(delete);
         n_perf += int'(hit_perfect);
         n_good += int'(hit_good);
         n_miss += int'(miss);
         if ((delete && miss) || (hit_perfect && hit_good) ||
             ((hit_perfect || hit_good) != delete)) n_bad++;
      end
   endtask

   task automatic expect_pulses(input string tag, input int d, input int p, input int g, input int m);
      check({tag, ".delete"},  n_del,  d);
      check({tag, ".perfect"}, n_perf, p);
      check({tag, ".good"},    n_good, g);
      check({tag, ".miss"},    n_miss, m);
      check({tag, ".excl"},    n_bad,  0);
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst.delete", delete, 0);
      check("rst.miss", miss, 0);
      check("rst.score", score, 0);
      check("rst.max_combo", max_combo, 0);
      check("rst.result_valid", result_valid, 0);
      rst = 1'b0;
      tick(3);

      // Red note arrives, offset 3, red press: perfect, score 2
      offset = 3'd3; note_R_judge = 1'b1; tick(2);
      press(1'b1, 1'b0);
      expect_pulses("red_perfect", 1, 1, 0, 0);
      check("red_perfect.score", score, 2);
      note_R_judge = 1'b0; tick(25);

      // Blue note at offset 6: good, score 3; second press inside lockout is ignored
      offset = 3'd6; note_B_judge = 1'b1; tick(2);
      press(1'b0, 1'b1);
      expect_pulses("blue_good", 1, 0, 1, 0);
      check("blue_good.score", score, 3);
      press(1'b0, 1'b1);
      expect_pulses("blue_lockout", 0, 0, 0, 0);
      check("blue_lockout.score", score, 3);
      note_B_judge = 1'b0; tick(25);

      // Red note, wrong colour: miss only; then red press still hits (good at offset 6)
      note_R_judge = 1'b1; tick(2);
      press(1'b0, 1'b1);
      expect_pulses("wrong_colour", 0, 0, 0, 1);
      check("wrong_colour.score", score, 3);
      press(1'b1, 1'b0);
      expect_pulses("after_wrong", 1, 0, 1, 0);
      check("after_wrong.score", score, 4);
      note_R_judge = 1'b0; tick(25);

      // Both buttons in the same cycle: single miss
      offset = 3'd3; note_R_judge = 1'b1; tick(2);
      press(1'b1, 1'b1);
      expect_pulses("both", 0, 0, 0, 1);
      check("both.score", score, 4);
      tick(25);

      // Press with no note (arm clear): miss
      note_R_judge = 1'b0; tick(2);
      press(1'b1, 1'b0);
      expect_pulses("unarmed", 0, 0, 0, 1);
      check("unarmed.score", score, 4);
      tick(25);

      // Perfect to 6, re-arm via offset wrap 6->0, perfect saturates at 7
      note_R_judge = 1'b1; tick(2);
      press(1'b1, 1'b0);
      expect_pulses("perfect6", 1, 1, 0, 0);
      check("perfect6.score", score, 6);
      tick(25);
      offset = 3'd6; tick(1);
      offset = 3'd0; tick(1);
      offset = 3'd3; tick(1);
      press(1'b1, 1'b0);
      expect_pulses("saturate", 1, 1, 0, 0);
      check("saturate.score", score, 7);
      tick(25);

      // max_combo tracking, HOLD freezes everything, release clears results
      combo = 8'd3; tick(1);
      combo = 8'd7; tick(1);
      combo = 8'd0; tick(1);
      combo = 8'd5; tick(1);
      check("max_combo", max_combo, 7);
      finish = 1'b1; tick(2);
      check("hold.result_valid", result_valid, 1);
      combo = 8'd9;
      press(1'b1, 1'b0);
      expect_pulses("hold_press", 0, 0, 0, 0);
      check("hold.score", score, 7);
      check("hold.max_combo", max_combo, 7);
      combo = 8'd0; finish = 1'b0; tick(2);
      check("release.score", score, 0);
      check("release.max_combo", max_combo, 0);
      check("release.result_valid", result_valid, 0);
      tick(25);

      // Reset mid-lockout: next press after release is judged normally
      note_R_judge = 1'b0; tick(1);
      note_R_judge = 1'b1; tick(2);
      press(1'b1, 1'b0);
      expect_pulses("pre_rst", 1, 1, 0, 0);
      check("pre_rst.score", score, 2);
      rst = 1'b1; #1;
      check("mid_rst.score", score, 0);
      tick(1);
      rst = 1'b0; tick(2);
      press(1'b1, 1'b0);
      expect_pulses("post_rst", 1, 1, 0, 0);
      check("post_rst.score", score, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
